// File: rtl/bcd_scan_display.sv
// Time-multiplexed seven-segment driver for packed BCD digits.
// A shadow/display register pair gives tear-free frame updates; optional leading-zero blanking.
module bcd_scan_display #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 1000
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic [4*NUM_DIGITS-1:0]                                bcd_in,
    input  logic                                                   load,
    input  logic                                                   blank_lz,
    output logic [6:0]                                             seg_n,
    output logic [NUM_DIGITS-1:0]                                  an_n,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
    output logic                                                   frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]          pre_cnt;
    logic [IDX_W-1:0]          idx;
    logic [4*NUM_DIGITS-1:0]   shadow;
    logic [4*NUM_DIGITS-1:0]   display;
    logic                      pending;

    logic                      pre_wrap;
    logic                      frame_end;
    logic [3:0]                digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]     lz_mask;
    logic                      upper_zero;
    logic                      slot_dark;
    logic [6:0]                seg_next;
    logic [NUM_DIGITS-1:0]     an_next;

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b0111111;
        endcase
        return p;
    endfunction

    assign pre_wrap  = (pre_cnt == PRE_LAST);
    assign frame_end = pre_wrap && (idx == IDX_LAST);
    assign digit_idx = idx;

    // lz_mask[k] is set when display digits NUM_DIGITS-1 down to k are all zero; digit 0 never blanks
    always_comb begin
        upper_zero = 1'b1;
        lz_mask    = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            digits[i] = display[4*i +: 4];
        end
        for (int unsigned i = NUM_DIGITS; i > 1; i--) begin
            upper_zero   = upper_zero && (digits[i-1] == 4'd0);
            lz_mask[i-1] = upper_zero;
        end
    end

    always_comb begin
        slot_dark = (pre_cnt == '0) || (blank_lz && lz_mask[idx]);
        an_next   = '1;
        seg_next  = 7'h7F;
        if (!slot_dark) begin
            an_next[idx] = 1'b0;
            seg_next     = seg_pattern(digits[idx]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt    <= '0;
            idx        <= '0;
            shadow     <= '0;
            display    <= '0;
            pending    <= 1'b0;
            seg_n      <= 7'h7F;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            pre_cnt <= pre_wrap ? '0 : pre_cnt + 1'b1;
            if (pre_wrap) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            if (load) begin
                shadow <= bcd_in;
            end
            // A load on the boundary edge bypasses the shadow so the newest value is shown
            if (frame_end) begin
                if (load) begin
                    display <= bcd_in;
                end else if (pending) begin
                    display <= shadow;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
            frame_done <= frame_end;
            seg_n      <= seg_next;
            an_n       <= an_next;
        end
    end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Time-multiplexed seven-segment driver that consumes the packed BCD digits produced by the decimal counter chain. It scans one digit at a time onto a shared active-low segment bus, with a per-digit active-low anode enable. The shadow/display register pair makes updates tear-free, and the block supports optional leading-zero blanking. It sits directly downstream of the decimal counters and drives the board display pins.

## Interface
- NUM_DIGITS, 4: number of digits scanned; minimum 1.
- PRESCALE, 1000: clk cycles per digit slot; minimum 2.

- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- bcd_in  input  4*NUM_DIGITS  packed BCD digits; digit k in bits [4k+3:4k], digit 0 least significant.
- load  input  1  capture strobe; bcd_in is sampled on any clk edge with load=1.
- blank_lz  input  1  leading-zero blanking enable; level, sampled every cycle.
- seg_n  output  7  segments, active low; bit0=a … bit6=g.
- an_n  output  NUM_DIGITS  digit enables, active low; at most one bit low at a time.
- digit_idx  output  clog2(NUM_DIGITS) (min 1)  index of the digit slot in progress.
- frame_done  output  1  one-cycle pulse at the start of each new frame.

## Operation
- Internal state:
  - pre_cnt: 0..PRESCALE-1.
  - idx: 0..NUM_DIGITS-1; drives digit_idx directly.
  - shadow: 4*NUM_DIGITS bits.
  - display: 4*NUM_DIGITS bits.
  - pending: 1 bit.
- Scan sequencing:
  - pre_cnt increments every cycle and wraps from PRESCALE-1 to 0.
  - On that wrap, idx increments and wraps from NUM_DIGITS-1 to 0.
  - Scan order is digit 0, 1, …, NUM_DIGITS-1, 0, …
- Capture:
  - load=1 writes shadow<=bcd_in and sets pending.
  - A second load before a frame boundary overwrites shadow; the latest value wins.
- Frame boundary (pre_cnt==PRESCALE-1 and idx==NUM_DIGITS-1):
  - If load=1 on the same edge, display<=bcd_in.
  - Otherwise, if pending=1, display<=shadow.
  - pending clears either way.
  - display changes only at frame boundaries.
- Digit decode:
  - 0–9 map to the standard patterns.
  - Values 10–15 display '-' (g only, seg_n=7'b0111111).
- Leading-zero blanking: with blank_lz=1, digit k (k≥1) is blanked if display digits NUM_DIGITS-1 down to k are all 0. Digit 0 is never blanked.
- Blanked slot: an_n all ones, seg_n=7'h7F.
- Anti-ghosting: in every slot, the cycle with pre_cnt==0 forces an_n all ones and seg_n=7'h7F.

## Timing
- Reset values:
  - Outputs: seg_n=7'h7F, an_n all ones, digit_idx=0, frame_done=0.
  - State: pre_cnt=0, shadow=0, display=0, pending=0.
- seg_n and an_n are registered. Their value in cycle t+1 is decoded from (idx, pre_cnt, display, blank_lz) in cycle t, so the pins lag digit_idx by one cycle.
- digit_idx is the idx register itself, with zero lag.
- frame_done is registered. It is high exactly in the cycle where idx==0 and pre_cnt==0, excluding the first cycle after reset release.
- Digit period: PRESCALE cycles. Frame period: NUM_DIGITS*PRESCALE cycles.
- Update latency: new display is first visible on the pins 2 cycles after the frame boundary edge. This is the pre_cnt==1 decode of slot 0.
- Reset asserted mid-scan: all state returns to reset values immediately (asynchronous). Pending data is discarded.
- After reset release: the first edge starts slot 0 from pre_cnt=0. The first displayed frame shows display=0, i.e. '0' on every digit with blank_lz=0, or only digit 0 with blank_lz=1.
- Rate and counter rules:
  - load may be asserted every cycle.
  - No back-pressure; load is never ignored.
  - Counter arithmetic is modular with no overflow flags.

## Test plan
- Reset: hold rst_n=0 → seg_n=7'h7F, an_n=4'hF, digit_idx=0, frame_done=0. Release → digit_idx steps 0,1,2,3,0 every PRESCALE cycles.
- Basic scan (PRESCALE=4, NUM_DIGITS=4, blank_lz=0):
  - Stimulus: load bcd_in=16'h1234, then wait one frame.
  - Slot 0 → an_n=4'b1110, seg_n=7'b0011001 ('4').
  - Slot 3 → an_n=4'b0111, seg_n=7'b1111001 ('1').
  - Each slot's pre_cnt==0 decode → an_n=4'hF.
- Leading-zero blanking:
  - Stimulus: load 16'h0070, blank_lz=1.
  - Slots 3 and 2 → an_n=4'hF.
  - Slot 1 → '7' (7'b1111000).
  - Slot 0 → '0' (7'b1000000).
  - With 16'h0000, only slot 0 is lit, showing '0'.
- Invalid digit: load 16'h00A5 → slot 1 shows seg_n=7'b0111111 and slot 0 shows '5' (7'b0010010).
- Tear-free update and priority:
  - Stimulus: load 16'h1111 mid-frame while display holds 16'h2222.
  - Remaining slots still show '2'.
  - From the next frame after frame_done, all digits show '1'.
  - A load coinciding with the boundary edge is the value displayed.
- Reset mid-scan: assert rst_n=0 during slot 2 with pending=1 → outputs are at reset values in the same cycle. After release, display is 0 and the pending data is never shown.
